// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and data bundle for alu_pipe.
//   Upstream side : in_valid/in_ready, operands x/y, ALU controls zx/nx/zy/ny/f/no,
//                   use_acc (x <- accumulator), acc_clr (accumulator treated as reset value).
//   Downstream side: out_valid/out_ready, result o, flags zr/ng/cy/ov.
//   acc           : current accumulator value, driven by the ALU.
// Modport slave is the ALU side; master is the producer/consumer side.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic             use_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             zr;
    logic             ng;
    logic             cy;
    logic             ov;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, x, y, zx, nx, zy, ny, f, no, use_acc, acc_clr, out_ready,
        input  in_ready, out_valid, o, zr, ng, cy, ov, acc
    );

    modport slave (
        input  in_valid, x, y, zx, nx, zy, ny, f, no, use_acc, acc_clr, out_ready,
        output in_ready, out_valid, o, zr, ng, cy, ov, acc
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined zx/nx/zy/ny/f/no ALU with valid/ready handshake on both
// sides, a chaining accumulator and carry/overflow flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards in-flight ops, acc <- ACC_RST)
//   bus   : alu_pipe_if.slave -- input op handshake, result handshake, flags, acc
// S1 only captures the op; S2 computes and registers the result and flags.
module alu_pipe #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);

    localparam int unsigned MSB = WIDTH - 1;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q, s1_x_d;
    logic [WIDTH-1:0] s1_y_q, s1_y_d;
    logic [5:0]       s1_ctrl_q, s1_ctrl_d;  // {zx, nx, zy, ny, f, no}
    logic             s1_use_acc_q, s1_use_acc_d;
    logic             s1_acc_clr_q, s1_acc_clr_d;

    // Stage 2 registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             cy_q, cy_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // Handshake
    logic s2_en;
    logic in_ready;
    logic accept;
    logic s2_load;

    assign s2_en    = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_en;
    assign accept   = bus.in_valid && in_ready;
    assign s2_load  = s2_en && s1_valid_q;

    // Decoded S1 controls
    logic c_zx, c_nx, c_zy, c_ny, c_f, c_no;
    assign {c_zx, c_nx, c_zy, c_ny, c_f, c_no} = s1_ctrl_q;

    // S2 datapath
    logic [WIDTH-1:0] xs, x1, x2, y1, y2, z, o_new;
    logic [WIDTH:0]   sum;
    logic             cy_new, ov_new;

    always_comb begin
        // acc_clr makes the op see ACC_RST as the accumulator, so a chain can restart
        // without a separate clear cycle.
        xs     = s1_use_acc_q ? (s1_acc_clr_q ? ACC_RST : acc_q) : s1_x_q;
        x1     = c_zx ? '0 : xs;
        x2     = c_nx ? ~x1 : x1;
        y1     = c_zy ? '0 : s1_y_q;
        y2     = c_ny ? ~y1 : y1;
        sum    = {1'b0, x2} + {1'b0, y2};
        z      = c_f ? sum[MSB:0] : (x2 & y2);
        o_new  = c_no ? ~z : z;
        // Flags come from the pre-inversion result so 'no' leaves cy/ov untouched.
        cy_new = c_f & sum[WIDTH];
        ov_new = c_f & (x2[MSB] == y2[MSB]) & (z[MSB] != x2[MSB]);
    end

    // Next-state logic
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_use_acc_d = s1_use_acc_q;
        s1_acc_clr_d = s1_acc_clr_q;
        out_valid_d  = out_valid_q;
        o_d          = o_q;
        zr_d         = zr_q;
        ng_d         = ng_q;
        cy_d         = cy_q;
        ov_d         = ov_q;
        acc_d        = acc_q;

        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_x_d       = bus.x;
            s1_y_d       = bus.y;
            s1_ctrl_d    = {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no};
            s1_use_acc_d = bus.use_acc;
            s1_acc_clr_d = bus.acc_clr;
        end else if (s2_en) begin
            s1_valid_d = 1'b0;
        end

        if (s2_en) begin
            out_valid_d = s1_valid_q;
        end

        if (s2_load) begin
            o_d   = o_new;
            zr_d  = ~|o_new;
            ng_d  = o_new[MSB];
            cy_d  = cy_new;
            ov_d  = ov_new;
            // Accumulator tracks every completed op, giving hazard-free chaining.
            acc_d = o_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_ctrl_q    <= '0;
            s1_use_acc_q <= 1'b0;
            s1_acc_clr_q <= 1'b0;
            out_valid_q  <= 1'b0;
            o_q          <= '0;
            zr_q         <= 1'b0;
            ng_q         <= 1'b0;
            cy_q         <= 1'b0;
            ov_q         <= 1'b0;
            acc_q        <= ACC_RST;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_use_acc_q <= s1_use_acc_d;
            s1_acc_clr_q <= s1_acc_clr_d;
            out_valid_q  <= out_valid_d;
            o_q          <= o_d;
            zr_q         <= zr_d;
            ng_q         <= ng_d;
            cy_q         <= cy_d;
            ov_q         <= ov_d;
            acc_q        <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.o         = o_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.cy        = cy_q;
    assign bus.ov        = ov_q;
    assign bus.acc       = acc_q;

endmodule
